// File: rtl/gate_sweep_checker_if.sv
// Bundle between the sweep checker and the gate under test / result consumer.
// The master side drives the stimulus and results; the slave side supplies start and resp.
interface gate_sweep_checker_if #(
    parameter int unsigned N_IN = 2
);
    logic              start;
    logic [N_IN-1:0]   stim;
    logic              resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail;
    logic              first_fail_valid;

    modport master (
        input  start, resp,
        output stim, busy, done, pass, err_count, first_fail, first_fail_valid
    );

    modport slave (
        output start, resp,
        input  stim, busy, done, pass, err_count, first_fail, first_fail_valid
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive response checker: sweeps all 2^N_IN input vectors in ascending order,
// samples resp after SETTLE cycles and compares it against the TRUTH table.
module gate_sweep_checker #(
    parameter int unsigned              N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]     TRUTH  = 4'b0111,
    parameter int unsigned              SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_sweep_checker_if.master  sweep_if
);
    localparam int unsigned NVEC = 2 ** N_IN;
    localparam int unsigned VW   = N_IN + 1;
    localparam int unsigned SW   = 8;

    localparam logic [VW-1:0] LAST_VEC    = VW'(NVEC - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [VW-1:0]     vec_q, vec_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [VW-1:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              ffv_q, ffv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              mismatch_c;

    // The vector counter is one bit wider than stim so the last-vector compare never wraps.
    assign mismatch_c = (sweep_if.resp != TRUTH[vec_q[N_IN-1:0]]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            ffv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            ffv_q    <= ffv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pass_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (sweep_if.start) begin
                    state_d  = S_DRIVE;
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    ffv_d    = 1'b0;
                end
            end
            S_DRIVE: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (mismatch_c) begin
                    err_d = err_q + VW'(1);
                    if (!ffv_q) begin
                        ff_d  = vec_q[N_IN-1:0];
                        ffv_d = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = S_DONE;
                end else begin
                    vec_d    = vec_q + VW'(1);
                    settle_d = '0;
                    state_d  = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0);
    end

    assign sweep_if.stim             = vec_q[N_IN-1:0];
    assign sweep_if.busy             = busy_q;
    assign sweep_if.done             = done_q;
    assign sweep_if.pass             = pass_q;
    assign sweep_if.err_count        = err_q;
    assign sweep_if.first_fail       = ff_q;
    assign sweep_if.first_fail_valid = ffv_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: behavioural gates answer the sweep, a scoreboard holds
// the expected verdict of each sweep until the checker reports done.
module tb_gate_sweep_checker;
    localparam int MODE_NAND   = 0;
    localparam int MODE_STUCK1 = 1;
    localparam int MODE_AND    = 2;

    typedef struct {
        int err;
        int ff;
        int ffv;
        int pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   mode_a;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    gate_sweep_checker_if #(.N_IN(2)) a_if ();
    gate_sweep_checker_if #(.N_IN(2)) b_if ();

    gate_sweep_checker #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(1)) u_a (
        .clk      (clk),
        .rst      (rst),
        .sweep_if (a_if.master)
    );

    gate_sweep_checker #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(3)) u_b (
        .clk      (clk),
        .rst      (rst),
        .sweep_if (b_if.master)
    );

    always #5 clk = ~clk;

    // stim = {A,B}
    function automatic logic gate(input int m, input logic [1:0] v);
        case (m)
            MODE_NAND:   return ~(v[1] & v[0]);
            MODE_STUCK1: return 1'b1;
            default:     return v[1] & v[0];
        endcase
    endfunction

    assign a_if.resp = gate(mode_a, a_if.stim);
    assign b_if.resp = gate(MODE_NAND, b_if.stim);

    function automatic exp_t model(input int m);
        exp_t e;
        logic [1:0] vv;
        e.err = 0; e.ff = 0; e.ffv = 0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (gate(m, vv) !== ~(vv[1] & vv[0])) begin
                if (e.ffv == 0) begin
                    e.ff  = v;
                    e.ffv = 1;
                end
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_stim(input bit s);
        return s ? 32'(b_if.stim) : 32'(a_if.stim);
    endfunction
    function automatic logic [31:0] o_busy(input bit s);
        return s ? 32'(b_if.busy) : 32'(a_if.busy);
    endfunction
    function automatic logic [31:0] o_done(input bit s);
        return s ? 32'(b_if.done) : 32'(a_if.done);
    endfunction
    function automatic logic [31:0] o_pass(input bit s);
        return s ? 32'(b_if.pass) : 32'(a_if.pass);
    endfunction
    function automatic logic [31:0] o_err(input bit s);
        return s ? 32'(b_if.err_count) : 32'(a_if.err_count);
    endfunction
    function automatic logic [31:0] o_ff(input bit s);
        return s ? 32'(b_if.first_fail) : 32'(a_if.first_fail);
    endfunction
    function automatic logic [31:0] o_ffv(input bit s);
        return s ? 32'(b_if.first_fail_valid) : 32'(a_if.first_fail_valid);
    endfunction

    task automatic set_start(input bit s, input logic v);
        if (s) b_if.start = v;
        else   a_if.start = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stim"}, o_stim(0), 0);
        chk({tag, "_busy"}, o_busy(0), 0);
        chk({tag, "_done"}, o_done(0), 0);
        chk({tag, "_pass"}, o_pass(0), 0);
        chk({tag, "_err"},  o_err(0),  0);
        chk({tag, "_ff"},   o_ff(0),   0);
        chk({tag, "_ffv"},  o_ffv(0),  0);
    endtask

    // Called at a negedge with the checker in IDLE or DONE; start is sampled at the next edge.
    task automatic do_sweep(input bit s, input int m, input bit pulse);
        int   per;
        exp_t e;
        per = s ? 4 : 2;
        if (!s) mode_a = m;
        sb.push_back(model(m));
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        chk("clear_err", o_err(s), 0);
        chk("clear_ffv", o_ffv(s), 0);
        for (int j = 0; j < 4 * per; j++) begin
            chk("busy_hi",  o_busy(s), 1);
            chk("done_lo",  o_done(s), 0);
            chk("stim_seq", o_stim(s), 32'(j / per));
            set_start(s, (pulse && (j == 2 || j == 4)) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        set_start(s, 1'b0);
        chk("done_at", o_done(s), 1);
        chk("busy_lo", o_busy(s), 0);
        chk("stim_last", o_stim(s), 3);
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("err_count",  o_err(s),  32'(e.err));
            chk("first_fail", o_ff(s),   32'(e.ff));
            chk("ff_valid",   o_ffv(s),  32'(e.ffv));
            chk("pass",       o_pass(s), 32'(e.pass));
        end
    endtask

    initial begin
        rst = 1'b1;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        mode_a = MODE_NAND;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst");

        do_sweep(0, MODE_NAND,   0);
        do_sweep(0, MODE_STUCK1, 1);
        do_sweep(0, MODE_AND,    0);
        do_sweep(0, MODE_NAND,   0);

        // Reset three cycles into a sweep discards everything.
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", o_busy(0), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midrst");
        @(negedge clk);
        chk_reset("midrst_hold");
        do_sweep(0, MODE_NAND, 0);

        do_sweep(1, MODE_NAND, 0);
        do_sweep(1, MODE_NAND, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesizable exhaustive response checker for small combinational gates (NAND2 and peers). On `start` it drives every input vector onto `stim` in ascending order and samples the gate's `resp` after a fixed settle time. It compares each sample against a parameterised truth table, then reports the mismatch count, the first failing vector and a pass flag. It is the response-reading counterpart to the display-only stimulus benches, and it lets gate checks run self-checking in simulation or on-chip.

## Interface
- `N_IN`, default 2: number of gate inputs; 2^N_IN vectors swept.
- `TRUTH`, default 4'b0111: expected output per vector; bit i is the expected `resp` for `stim == i` (default is NAND2 with stim = {A,B}). Width 2^N_IN.
- `SETTLE`, default 1: cycles `stim` is held before the sample cycle; legal range 1..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `start` in 1: begin a sweep. Sampled only in IDLE or DONE.
- `stim` out N_IN: current input vector to the gate under test.
- `resp` in 1: gate output.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: high in DONE; results valid.
- `pass` out 1: high in DONE when `err_count == 0`.
- `err_count` out N_IN+1: number of mismatching vectors, 0..2^N_IN.
- `first_fail` out N_IN: lowest vector that mismatched.
- `first_fail_valid` out 1: `first_fail` holds a captured value.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE → DRIVE on `start`.
  - On that edge: vector counter := 0, settle counter := 0, `err_count` := 0, `first_fail_valid` := 0, `first_fail` := 0.
- DRIVE:
  - `stim` = vector counter.
  - The settle counter increments each cycle.
  - After SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE: one cycle. `stim` is unchanged. `resp` is compared with TRUTH[vector] at the end of the cycle. On mismatch:
  - `err_count` += 1.
  - If `first_fail_valid` == 0: `first_fail` := vector and `first_fail_valid` := 1.
- SAMPLE exit:
  - If vector == 2^N_IN−1, go to DONE.
  - Otherwise vector += 1, settle counter := 0, go to DRIVE.
- DONE:
  - `done` = 1 and `pass` = (`err_count` == 0).
  - Results hold indefinitely.
  - `start` restarts exactly as from IDLE (same clears), so the next sweep begins with no idle cycle.
- `start` in DRIVE or SAMPLE is ignored. There is no abort other than `rst`.
- Vector counter width is N_IN+1 internally so the last-vector compare does not wrap. `stim` is its low N_IN bits.
- The `err_count` maximum is 2^N_IN, which fits N_IN+1 bits. No saturation is needed.
- `busy` = (state is DRIVE or SAMPLE). `busy` and `done` are never high together.

## Timing
- Reset values:
  - state IDLE.
  - `stim` = 0, `busy` = 0, `done` = 0, `pass` = 0.
  - `err_count` = 0, `first_fail` = 0, `first_fail_valid` = 0.
- `rst` has priority over `start` in the same cycle.
- `rst` asserted mid-sweep returns the block to reset values on that edge. Partial results are discarded.
- `start` high at edge k:
  - `busy` = 1 and `stim` = 0 from cycle k+1.
  - Each vector occupies SETTLE+1 cycles; vector i appears at cycle k+1+i·(SETTLE+1).
  - `resp` for vector i is sampled at the edge ending cycle k+(i+1)·(SETTLE+1).
  - `done` rises at cycle k+1+2^N_IN·(SETTLE+1).
  - For defaults that is k+9, with `busy` high for 8 cycles.
- Results (`err_count`, `first_fail*`) update on the SAMPLE edge. They are visible the following cycle.
- `stim` in IDLE and DONE: IDLE holds 0; DONE holds the last vector.

## Test plan
- Correct NAND2 DUT, defaults, `start` at cycle 2:
  - `stim` steps 0,1,2,3 every 2 cycles from cycle 3.
  - `done` = 1 at cycle 11, `pass` = 1, `err_count` = 0, `first_fail_valid` = 0.
- Stuck-at-1 DUT (`resp` = 1):
  - `err_count` = 1, `first_fail` = 2'b11, `first_fail_valid` = 1, `pass` = 0.
- AND2 DUT:
  - `err_count` = 4, `first_fail` = 2'b00, `pass` = 0.
- `start` pulsed again at cycles 5 and 7 during the sweep:
  - Ignored; `done` still at cycle 11 with unchanged results.
  - `start` in DONE restarts: `err_count` cleared, `busy` next cycle.
- `rst` at cycle 6 mid-sweep:
  - All outputs return to reset values at cycle 7.
  - A following `start` completes a normal 8-cycle sweep.
- SETTLE=3 with correct DUT and `start` at cycle 0:
  - Each vector held 4 cycles; `done` at cycle 17, `pass` = 1.
